// File: rtl/sample_ram_arbiter.sv
// sample_ram_arbiter: ping-pong 2-bank sample RAM arbiter, write priority with bounded read starvation.
// Define ARB_STATS_EN to add swap_count and wr_stall_count outputs.
module sample_ram_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              display_idle,
  output logic [ADDR_W:0]   ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              bank_sel,
  output logic              frame_ready
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       swap_count,
  output logic [15:0]       wr_stall_count
`endif
);
  typedef enum logic {FILLING, FULL} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t state_q, state_d;
  logic bank_sel_q, bank_sel_d, rd_valid_q, rd_valid_d, swap;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [ADDR_W:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  always_comb begin
    wr_gnt = wr_req && state_q == FILLING && !(rd_req && starve_cnt_q == LIMIT);
    rd_gnt = rd_req && !wr_gnt;
    // a swap must not split a read from its returning data
    swap = state_q == FULL && display_idle && !rd_valid_q && !rd_gnt;
    ram_addr_d = wr_gnt ? {bank_sel_q, wr_addr} : rd_gnt ? {~bank_sel_q, rd_addr} : ram_addr_q;
    ram_wdata_d = wr_gnt ? wr_data : ram_wdata_q;
    rd_valid_d = rd_gnt;
    bank_sel_d = bank_sel_q ^ swap;
    state_d = swap ? FILLING : (wr_gnt && wr_last) ? FULL : state_q;
    starve_cnt_d = (swap || rd_gnt || !rd_req) ? 4'd0 :
                   (wr_gnt && starve_cnt_q != LIMIT) ? starve_cnt_q + 4'd1 : starve_cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FILLING;
      bank_sel_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      starve_cnt_q <= 4'd0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      bank_sel_q   <= bank_sel_d;
      rd_valid_q   <= rd_valid_d;
      starve_cnt_q <= starve_cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end
  assign ram_addr    = ram_addr_d;
  assign ram_wdata   = ram_wdata_d;
  assign ram_we      = wr_gnt;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = ram_rdata;
  assign bank_sel    = bank_sel_q;
  assign frame_ready = state_q == FULL;
`ifdef ARB_STATS_EN
  logic [15:0] swap_count_q, swap_count_d, wr_stall_count_q, wr_stall_count_d;
  always_comb begin
    swap_count_d = swap ? swap_count_q + 16'd1 : swap_count_q;
    wr_stall_count_d = (wr_req && !wr_gnt && wr_stall_count_q != 16'hFFFF) ? wr_stall_count_q + 16'd1 : wr_stall_count_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swap_count_q     <= '0;
      wr_stall_count_q <= '0;
    end else begin
      swap_count_q     <= swap_count_d;
      wr_stall_count_q <= wr_stall_count_d;
    end
  end
  assign swap_count     = swap_count_q;
  assign wr_stall_count = wr_stall_count_q;
`endif
endmodule

// File: tb/tb_sample_ram_arbiter.sv
// tb_sample_ram_arbiter: vector table, hand sequences and random traffic against a reference model with a RAM model.
module tb_sample_ram_arbiter;
  localparam int STARVE_LIMIT = 4;
  logic clk = 0, reset = 0;
  logic wr_req = 0, wr_last = 0, rd_req = 0, display_idle = 0;
  logic [7:0] wr_addr = 0, wr_data = 0, rd_addr = 0, ram_rdata = 0, rd_data, ram_wdata;
  logic wr_gnt, rd_gnt, rd_valid, ram_we, bank_sel, frame_ready;
  logic [8:0] ram_addr;
`ifdef ARB_STATS_EN
  logic [15:0] swap_count, wr_stall_count;
`endif
  sample_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_last(wr_last), .wr_gnt(wr_gnt), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .display_idle(display_idle), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .bank_sel(bank_sel),
    .frame_ready(frame_ready)
`ifdef ARB_STATS_EN
    , .swap_count(swap_count), .wr_stall_count(wr_stall_count)
`endif
  );
  always #5 clk = ~clk;
  logic [7:0] mem [512];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else ram_rdata <= mem[ram_addr];
  end
  int total = 0, bad = 0;
  int m_bank, m_starve, m_addr, m_swaps, m_stall;
  bit m_full, m_rdv, m_rdok, m_known, m_wknown;
  logic [7:0] m_wdata, m_rdexp;
  logic [7:0] sh [512];
  bit shv [512];
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc();
    bit e_wr, e_rd, swap;
    int e_addr;
    #2;
    e_wr = wr_req && !m_full && !(rd_req && m_starve >= STARVE_LIMIT);
    e_rd = rd_req && !e_wr;
    e_addr = e_wr ? m_bank * 256 + int'(wr_addr) : (1 - m_bank) * 256 + int'(rd_addr);
    chk("wr_gnt", wr_gnt, e_wr);
    chk("rd_gnt", rd_gnt, e_rd);
    chk("ram_we", ram_we, e_wr);
    if (e_wr || e_rd) chk("ram_addr", ram_addr, e_addr);
    else if (m_known) chk("ram_addr_hold", ram_addr, m_addr);
    if (e_wr) chk("ram_wdata", ram_wdata, wr_data);
    else if (m_wknown) chk("ram_wdata_hold", ram_wdata, m_wdata);
    chk("bank_sel", bank_sel, m_bank);
    chk("frame_ready", frame_ready, m_full);
    chk("rd_valid", rd_valid, m_rdv);
    if (m_rdv && m_rdok) chk("rd_data", rd_data, m_rdexp);
`ifdef ARB_STATS_EN
    chk("swap_count", swap_count, m_swaps & 16'hFFFF);
    chk("wr_stall_count", wr_stall_count, m_stall > 65535 ? 65535 : m_stall);
`endif
    swap = m_full && display_idle && !m_rdv && !e_rd;
    m_rdok = e_rd && shv[e_addr];
    m_rdexp = sh[e_addr];
    if (e_wr) begin
      sh[e_addr] = wr_data;
      shv[e_addr] = 1;
      m_wdata = wr_data;
      m_wknown = 1;
    end
    if (e_wr || e_rd) begin
      m_known = 1;
      m_addr = e_addr;
    end
    m_rdv = e_rd;
    if (wr_req && !e_wr) m_stall++;
    m_starve = (swap || e_rd || !rd_req) ? 0 : e_wr ? (m_starve + 1 > STARVE_LIMIT ? STARVE_LIMIT : m_starve + 1) : m_starve;
    if (swap) begin
      m_full = 0;
      m_bank ^= 1;
      m_swaps++;
    end else if (e_wr && wr_last) m_full = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 0;
    wr_req = 0; rd_req = 0; wr_last = 0; display_idle = 0;
    m_full = 0; m_bank = 0; m_starve = 0; m_rdv = 0; m_known = 0; m_wknown = 0;
    m_swaps = 0; m_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_bank_sel", bank_sel, 0);
    chk("rst_rd_valid", rd_valid, 0);
`ifdef ARB_STATS_EN
    chk("rst_swap_count", swap_count, 0);
    chk("rst_wr_stall_count", wr_stall_count, 0);
`endif
    reset = 1;
  endtask
  typedef struct {
    bit wr, last, rd, idle;
    bit e_wg, e_rg, e_fr, e_bs, e_rv;
  } vec_t;
  vec_t tbl [10];
  initial begin
    tbl[0] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
    tbl[4] = '{1, 0, 1, 0, 1, 0, 0, 0, 0};
    tbl[5] = '{1, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[6] = '{1, 1, 0, 1, 1, 0, 0, 0, 1};
    tbl[7] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
    tbl[8] = '{0, 0, 1, 0, 0, 1, 0, 1, 0};
    tbl[9] = '{1, 0, 0, 0, 1, 0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 256; i++) begin
      wr_req = 1; wr_addr = 8'(i); wr_data = 8'($urandom); wr_last = (i == 255);
      #1;
      chk("s1_addr", ram_addr, i);
      chk("s1_we", ram_we, 1);
      cyc();
    end
    wr_req = 0; wr_last = 0;
    #1 chk("s1_frame_ready", frame_ready, 1);
    wr_req = 1;
    repeat (10) begin
      #1;
      chk("s2_stall_gnt", wr_gnt, 0);
      chk("s2_bank", bank_sel, 0);
      cyc();
    end
    display_idle = 1;
    cyc();
    wr_req = 0; display_idle = 0;
    #1;
    chk("s2_swap_bank", bank_sel, 1);
    chk("s2_swap_ready", frame_ready, 0);
    rd_req = 1; rd_addr = 8'h10;
    #1;
    chk("s3_rd_addr0", ram_addr, 9'h010);
    chk("s3_rd_we", ram_we, 0);
    cyc();
    rd_req = 0;
    #1 chk("s3_rd_valid", rd_valid, 1);
    cyc();
    wr_req = 1; wr_addr = 0; wr_last = 1;
    cyc();
    wr_req = 0; wr_last = 0; display_idle = 1;
    cyc();
    display_idle = 0;
    #1 chk("s3_bank_back", bank_sel, 0);
    rd_req = 1; rd_addr = 8'h10;
    #1 chk("s3_rd_addr1", ram_addr, 9'h110);
    cyc();
    rd_req = 0;
    cyc();
    wr_req = 1; wr_addr = 8'h05; wr_last = 1;
    cyc();
    wr_req = 0; wr_last = 0; display_idle = 1; rd_req = 1; rd_addr = 8'h03;
    #1;
    chk("s4_ready_a", frame_ready, 1);
    chk("s4_rd_gnt_a", rd_gnt, 1);
    cyc();
    rd_req = 0;
    #1;
    chk("s4_ready_b", frame_ready, 1);
    chk("s4_rd_valid_b", rd_valid, 1);
    cyc();
    #1;
    chk("s4_ready_c", frame_ready, 1);
    chk("s4_bank_c", bank_sel, 0);
    cyc();
    #1;
    chk("s4_ready_d", frame_ready, 0);
    chk("s4_bank_d", bank_sel, 1);
    display_idle = 0;
    wr_req = 1; wr_addr = 8'h07;
    cyc();
    wr_req = 0; rd_req = 1; rd_addr = 8'h01;
    cyc();
    rd_req = 0;
    #1;
    chk("s5_rd_valid_pre", rd_valid, 1);
    chk("s5_bank_pre", bank_sel, 1);
    #1 reset = 0;
    #1;
    chk("s5_async_bank", bank_sel, 0);
    chk("s5_async_ready", frame_ready, 0);
    chk("s5_async_rd_valid", rd_valid, 0);
`ifdef ARB_STATS_EN
    chk("s5_async_swap_count", swap_count, 0);
`endif
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr_req = tbl[i].wr; wr_last = tbl[i].last; rd_req = tbl[i].rd; display_idle = tbl[i].idle;
      wr_addr = 8'($urandom); rd_addr = 8'($urandom); wr_data = 8'($urandom);
      #1;
      chk($sformatf("tbl%0d_wr_gnt", i), wr_gnt, tbl[i].e_wg);
      chk($sformatf("tbl%0d_rd_gnt", i), rd_gnt, tbl[i].e_rg);
      chk($sformatf("tbl%0d_ram_we", i), ram_we, tbl[i].e_wg);
      chk($sformatf("tbl%0d_frame_ready", i), frame_ready, tbl[i].e_fr);
      chk($sformatf("tbl%0d_bank_sel", i), bank_sel, tbl[i].e_bs);
      chk($sformatf("tbl%0d_rd_valid", i), rd_valid, tbl[i].e_rv);
      cyc();
    end
    do_reset();
    repeat (3000) begin
      wr_req = $urandom_range(0, 9) < 7;
      rd_req = $urandom_range(0, 9) < 4;
      display_idle = $urandom_range(0, 9) < 3;
      wr_last = $urandom_range(0, 31) == 0;
      wr_addr = 8'($urandom); rd_addr = 8'($urandom); wr_data = 8'($urandom);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sample_ram_arbiter.md
Name: sample_ram_arbiter

Overview:
Controller that shares one single-port, synchronous-read 2-bank sample RAM (2 x 2^ADDR_W x DATA_W) between the wave capture writer and the wave display reader. It owns the ping-pong bank select: the writer fills one bank while the display reads the other. Banks swap only when a full frame is written and the display is idle. Per-cycle arbitration uses write priority with a bounded read-starvation limit.

Parameters:
ADDR_W, 8, per-bank address width; bank depth is 2^ADDR_W.
DATA_W, 8, sample width.
STARVE_LIMIT, 4, max consecutive write grants while rd_req is pending; legal range 1..15.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  asynchronous, active-low reset.
wr_req  in  1  writer requests a RAM write this cycle.
wr_addr  in  ADDR_W  write offset within the write bank.
wr_data  in  DATA_W  write sample.
wr_last  in  1  qualifies the current write as the final sample of a frame.
wr_gnt  out  1  write accepted this cycle.
rd_req  in  1  display requests a RAM read.
rd_addr  in  ADDR_W  read offset within the read bank.
rd_gnt  out  1  read issued this cycle.
rd_valid  out  1  rd_data valid; asserted the cycle after rd_gnt.
rd_data  out  DATA_W  read sample (= ram_rdata).
display_idle  in  1  display is between frames; a swap is allowed.
ram_addr  out  ADDR_W+1  {bank, offset} to RAM.
ram_we  out  1  RAM write strobe.
ram_wdata  out  DATA_W  RAM write data.
ram_rdata  in  DATA_W  RAM read data; 1-cycle latency.
bank_sel  out  1  bank being written; the display reads ~bank_sel.
frame_ready  out  1  a complete frame is held, awaiting swap.

Behaviour:
- Reset (reset=0, async): state=FILLING, bank_sel=0, starve_cnt=0, rd_valid=0. Combinational outputs evaluate with no grants: wr_gnt=0, rd_gnt=0, ram_we=0, frame_ready=0.
- Handshake: req/gnt. A requester holds req, addr and data stable until it sees gnt in the same cycle. gnt is combinational from req and state; at most one grant per cycle.
- Write eligibility: wr_req=1 and state=FILLING. In FULL, wr_gnt=0, so the writer stalls and the unread frame is never overwritten.
- Arbitration, both requests eligible: write wins unless starve_cnt==STARVE_LIMIT, in which case read wins. If only one request is eligible, it wins.
- starve_cnt (4b): increments when wr_gnt=1 and rd_req=1. Clears when rd_gnt=1 or rd_req=0. It saturates at STARVE_LIMIT and never wraps.
- RAM drive:
  - On wr_gnt: ram_we=1, ram_addr={bank_sel, wr_addr}, ram_wdata=wr_data.
  - On rd_gnt: ram_we=0, ram_addr={~bank_sel, rd_addr}.
  - With no grant: ram_we=0; ram_addr and ram_wdata hold their last value, so there is no toggle.
- Read latency: rd_valid is registered rd_gnt, giving exactly 1 cycle. rd_data passes ram_rdata through unregistered. Back-to-back reads give rd_valid every cycle.
- Swap FSM (1 bit):
  - FILLING -> FULL: on wr_gnt & wr_last. wr_last without wr_gnt is ignored.
  - FULL -> FILLING: when display_idle=1, rd_valid=0 and rd_gnt=0 in the same cycle. On that edge bank_sel toggles and starve_cnt clears.
  - frame_ready = (state==FULL).
- Simultaneous events:
  - If display_idle is high while the FILLING->FULL write is granted, the swap waits until the next cycle, so the minimum FULL dwell is 1 cycle.
  - Reads during FULL still target ~bank_sel, i.e. the old display bank, until the swap.
- Reset mid-frame: a partial frame is discarded, bank_sel returns to 0, and any rd_valid in flight is dropped.

Optional Feature:
ARB_STATS_EN:
- Defined: adds output swap_count[15:0], which increments on each bank swap and wraps 0xFFFF->0. Also adds wr_stall_count[15:0], which increments on each cycle with wr_req=1 and wr_gnt=0, and saturates at 0xFFFF. Both reset to 0.
- Undefined: both ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset release, wr_req=1 streaming addr 0..255 with wr_last on 255 -> ram_we=1 each cycle, ram_addr 0x000..0x0FF, frame_ready=1 on the cycle after addr 255.
- FULL with display_idle=0, wr_req=1 for 10 cycles -> wr_gnt=0 throughout, bank_sel=0. Then display_idle=1 -> next edge bank_sel=1, frame_ready=0.
- rd_req and wr_req both held high, STARVE_LIMIT=4 -> grants in the sequence W,W,W,W,R,W,W,W,W,R. rd_valid=1 exactly 1 cycle after each R, rd_data=ram_rdata.
- Read at rd_addr=0x10 with bank_sel=1 -> ram_addr=0x010 and ram_we=0. After swap, the same read gives ram_addr=0x110.
- FULL with display_idle=1 while a read is granted -> no swap that cycle or the next (rd_valid=1). Swap occurs on the first cycle with rd_gnt=0 and rd_valid=0.
- reset pulsed low mid-frame at bank_sel=1 -> bank_sel=0, frame_ready=0, and rd_valid=0 immediately (async). With ARB_STATS_EN defined, swap_count=0.
